// File: rtl/key_debounce.sv
// key_debounce: per-key synchroniser, debounce and press/release/long-press pulse generation
module key_debounce #(
  parameter int N_KEYS      = 2,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEB_CYCLES  = 50000,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [N_KEYS-1:0] in_key_raw,
  output logic [N_KEYS-1:0] o_key_level,
  output logic [N_KEYS-1:0] o_key_press,
  output logic [N_KEYS-1:0] o_key_release,
  output logic [N_KEYS-1:0] o_key_long
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
  typedef enum logic [1:0] {RELEASED, PRESSED, LONG_HELD} state_t;
  genvar i;
  for (i = 0; i < N_KEYS; i++) begin : g_key
    logic s1, s2, k, accept, level, press, release_p, lng;
    logic [DW-1:0] cnt;
    logic [HW-1:0] hold;
    state_t state;
    assign k      = s2 ^ ACTIVE_LOW;
    assign accept = (k != level) && (cnt == DEB_LAST);
    assign o_key_level[i]   = level;
    assign o_key_press[i]   = press;
    assign o_key_release[i] = release_p;
    assign o_key_long[i]    = lng;
    always_ff @(posedge in_clk) begin
      if (in_rst) begin
        s1        <= ACTIVE_LOW;
        s2        <= ACTIVE_LOW;
        cnt       <= '0;
        hold      <= '0;
        state     <= RELEASED;
        level     <= 1'b0;
        press     <= 1'b0;
        release_p <= 1'b0;
        lng       <= 1'b0;
      end else begin
        s1        <= in_key_raw[i];
        s2        <= s1;
        cnt       <= (k == level || accept) ? '0 : cnt + 1'b1;
        level     <= accept ? k : level;
        press     <= accept & k;
        release_p <= accept & ~k;
        lng       <= (state == PRESSED) && (hold == LONG_LAST) && !(accept && !k);
        if (accept && !k) begin
          state <= RELEASED;
          hold  <= '0;
        end else if (state == RELEASED && accept) begin
          state <= PRESSED;
          hold  <= '0;
        end else if (state == PRESSED && hold == LONG_LAST) begin
          state <= LONG_HELD;
        end else if (state == PRESSED) begin
          hold <= hold + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: randomized and directed stimulus checked against a sliding-window reference model
module tb_key_debounce;
  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  logic in_clk = 1'b0;
  logic in_rst = 1'b1;
  logic [N-1:0] in_key_raw = '1;
  logic [N-1:0] o_key_level, o_key_press, o_key_release, o_key_long;
  logic [N-1:0] e_lvl, e_pr, e_rel, e_long;
  int total = 0;
  int bad = 0;
  int t = 0;
  int long_seen = 0;
  bit hist[N][DEB+2];
  bit lvl[N];
  bit fired[N];
  int press_t[N];
  always #5 in_clk = ~in_clk;
  key_debounce #(
    .N_KEYS(N),
    .ACTIVE_LOW(1'b1),
    .DEB_CYCLES(DEB),
    .LONG_CYCLES(LONG)
  ) dut (
    .in_clk(in_clk),
    .in_rst(in_rst),
    .in_key_raw(in_key_raw),
    .o_key_level(o_key_level),
    .o_key_press(o_key_press),
    .o_key_release(o_key_release),
    .o_key_long(o_key_long)
  );
  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
    end
  endtask
  task automatic model(input bit rst, input logic [N-1:0] raw);
    bit acc;
    e_pr   = '0;
    e_rel  = '0;
    e_long = '0;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        for (int j = 0; j < DEB + 2; j++) hist[k][j] = 1'b0;
        lvl[k]   = 1'b0;
        fired[k] = 1'b0;
      end else begin
        for (int j = 0; j < DEB + 1; j++) hist[k][j] = hist[k][j+1];
        hist[k][DEB+1] = ~raw[k];
        acc = 1'b1;
        for (int j = 0; j < DEB; j++) if (hist[k][j] == lvl[k]) acc = 1'b0;
        if (acc && lvl[k]) begin
          e_rel[k] = 1'b1;
          lvl[k]   = 1'b0;
        end else if (acc) begin
          e_pr[k]    = 1'b1;
          lvl[k]     = 1'b1;
          press_t[k] = t;
          fired[k]   = 1'b0;
        end else if (lvl[k] && !fired[k] && t - press_t[k] == LONG) begin
          e_long[k] = 1'b1;
          fired[k]  = 1'b1;
        end
      end
      e_lvl[k] = lvl[k];
    end
  endtask
  task automatic step(input bit rst, input logic [N-1:0] raw, input string tag);
    @(negedge in_clk);
    in_rst     = rst;
    in_key_raw = raw;
    @(posedge in_clk);
    t++;
    model(rst, raw);
    #1;
    if (e_long != '0) long_seen++;
    check({tag, ".level"}, o_key_level, e_lvl);
    check({tag, ".press"}, o_key_press, e_pr);
    check({tag, ".release"}, o_key_release, e_rel);
    check({tag, ".long"}, o_key_long, e_long);
  endtask
  task automatic hold(input logic [N-1:0] raw, input int n, input string tag);
    repeat (n) step(1'b0, raw, tag);
  endtask
  initial begin
    logic [N-1:0] r;
    step(1'b1, 2'b11, "reset");
    step(1'b1, 2'b11, "reset");
    hold(2'b11, 10, "idle");
    hold(2'b10, 40, "long_press");
    hold(2'b11, 10, "long_release");
    hold(2'b10, 3, "bounce_press");
    hold(2'b11, 1, "bounce_press");
    hold(2'b10, 3, "bounce_press");
    hold(2'b11, 10, "bounce_press");
    hold(2'b10, 15, "short_press");
    hold(2'b11, 10, "short_release");
    hold(2'b10, 10, "bounce_rel");
    hold(2'b11, 3, "bounce_rel");
    hold(2'b10, 1, "bounce_rel");
    hold(2'b11, 3, "bounce_rel");
    hold(2'b10, 10, "bounce_rel");
    hold(2'b11, 10, "bounce_rel");
    hold(2'b00, 10, "simul");
    hold(2'b11, 10, "simul");
    hold(2'b10, 15, "mid_hold");
    step(1'b1, 2'b10, "mid_reset");
    hold(2'b10, 35, "after_reset");
    hold(2'b11, 10, "after_reset");
    if (long_seen < 2) begin
      total++;
      bad++;
      $display("FAIL long_coverage got=%0d exp>=2", long_seen);
    end
    r = 2'b11;
    repeat (300) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 3) == 0) r[k] = ~r[k];
      step($urandom_range(0, 149) == 0, r, "rand_fast");
    end
    repeat (700) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 29) == 0) r[k] = ~r[k];
      step($urandom_range(0, 299) == 0, r, "rand_slow");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
